fsbm_block_loader: RTL

Input-stage loader for the full-search block matching engine. It consumes the 32-bit packed pixel stream that the stimulus image memory produces; that memory also drives `init` and `rst_n`. It deserializes one current block and its search window into two on-chip pixel buffers. The loader then holds the loaded buffers for the PE array, which reads them through two random-access pixel ports. It sits directly downstream of the image source and upstream of the SAD/PE array.

---
 rtl/fsbm_pkg.sv | 21 ++
 rtl/fsbm_pix_ram.sv | 41 ++++
 rtl/fsbm_block_loader.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fsbm_pkg.sv
// Shared constants and the loader state type for the full-search block matching front end.
package fsbm_pkg;

    localparam int PIX_W     = 8;
    localparam int BLK       = 16;
    localparam int RANGE     = 16;
    localparam int SW_DIM    = BLK + 2 * RANGE;
    localparam int CUR_WORDS = BLK * BLK / 4;
    localparam int SW_WORDS  = SW_DIM * SW_DIM / 4;
    localparam int CUR_AW    = $clog2(BLK * BLK);
    localparam int SW_AW     = $clog2(SW_DIM * SW_DIM);
    localparam int WC_W      = $clog2(SW_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_CUR,
        ST_LOAD_SW,
        ST_FULL
    } ld_state_t;

endpackage

// File: rtl/fsbm_pix_ram.sv
// Pixel buffer: one packed four-pixel write port, one registered single-pixel read port.
module fsbm_pix_ram #(
    parameter  int PIX_W       = 8,
    parameter  int DEPTH_WORDS = 64,
    localparam int WAW         = $clog2(DEPTH_WORDS),
    localparam int PAW         = $clog2(DEPTH_WORDS * 4)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we_i,
    input  logic [WAW-1:0]     waddr_i,
    input  logic [4*PIX_W-1:0] wdata_i,
    input  logic [PAW-1:0]     raddr_i,
    output logic [PIX_W-1:0]   rdata_o
);
    import fsbm_pkg::*;

    logic [PIX_W-1:0] lane_q [4][DEPTH_WORDS];
    logic [PIX_W-1:0] rdata_q;

    // NOTE: storage arrays carry no reset so they map onto RAM macros; only the read register is reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int l = 0; l < 4; l++) begin
                lane_q[l][waddr_i] <= wdata_i[l*PIX_W +: PIX_W];
            end
        end
    end

    // Same-edge sampling of the old array contents gives read-before-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= lane_q[raddr_i[1:0]][raddr_i[PAW-1:2]];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fsbm_block_loader.sv
// Deserializes one current block and its search window from the packed pixel stream
// into two pixel buffers, then holds them for the PE array until released.
module fsbm_block_loader #(
    parameter  int PIX_W       = fsbm_pkg::PIX_W,
    parameter  int BLK         = fsbm_pkg::BLK,
    parameter  int RANGE       = fsbm_pkg::RANGE,
    localparam int P_SW_DIM    = BLK + 2 * RANGE,
    localparam int P_CUR_AW    = $clog2(BLK * BLK),
    localparam int P_SW_AW     = $clog2(P_SW_DIM * P_SW_DIM)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init,
    input  logic                in_valid,
    input  logic [4*PIX_W-1:0]  in_data,
    output logic                busy,
    output logic                blk_ready,
    output logic                load_done,
    input  logic                blk_release,
    output logic                ovf,
    input  logic [P_CUR_AW-1:0] cur_raddr,
    output logic [PIX_W-1:0]    cur_rdata,
    input  logic [P_SW_AW-1:0]  sw_raddr,
    output logic [PIX_W-1:0]    sw_rdata
);
    localparam int P_CUR_WORDS = BLK * BLK / 4;
    localparam int P_SW_WORDS  = P_SW_DIM * P_SW_DIM / 4;
    localparam int P_CUR_WAW   = $clog2(P_CUR_WORDS);
    localparam int P_WC_W      = $clog2(P_SW_WORDS);
    localparam logic [P_WC_W-1:0] CUR_LAST = P_WC_W'(P_CUR_WORDS - 1);
    localparam logic [P_WC_W-1:0] SW_LAST  = P_WC_W'(P_SW_WORDS - 1);

    import fsbm_pkg::*;

    ld_state_t         state_q, state_d;
    logic [P_WC_W-1:0] wc_q, wc_d;
    logic              load_done_q, load_done_d;
    logic              ovf_q, ovf_d;
    logic              cur_we, sw_we;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wc_q        <= '0;
            load_done_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wc_q        <= wc_d;
            load_done_q <= load_done_d;
            ovf_q       <= ovf_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        wc_d        = wc_q;
        load_done_d = 1'b0;
        ovf_d       = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (init) begin
                    state_d = ST_LOAD_CUR;
                    wc_d    = '0;
                end
            end
            ST_LOAD_CUR: begin
                if (init) begin
                    wc_d = '0;
                end else if (in_valid) begin
                    if (wc_q == CUR_LAST) begin
                        state_d = ST_LOAD_SW;
                        wc_d    = '0;
                    end else begin
                        wc_d = wc_q + P_WC_W'(1);
                    end
                end
            end
            ST_LOAD_SW: begin
                if (init) begin
                    state_d = ST_LOAD_CUR;
                    wc_d    = '0;
                end else if (in_valid) begin
                    if (wc_q == SW_LAST) begin
                        state_d     = ST_FULL;
                        wc_d        = '0;
                        load_done_d = 1'b1;
                    end else begin
                        wc_d = wc_q + P_WC_W'(1);
                    end
                end
            end
            ST_FULL: begin
                // A release takes priority; an init in the same cycle starts the next load at once.
                if (blk_release) begin
                    state_d = init ? ST_LOAD_CUR : ST_IDLE;
                    wc_d    = '0;
                end else if (init) begin
                    ovf_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_LOAD_CUR) || (state_q == ST_LOAD_SW);
        blk_ready = (state_q == ST_FULL);
        cur_we    = (state_q == ST_LOAD_CUR) && in_valid && !init;
        sw_we     = (state_q == ST_LOAD_SW) && in_valid && !init;
    end

    assign load_done = load_done_q;
    assign ovf       = ovf_q;

    fsbm_pix_ram #(
        .PIX_W      (PIX_W),
        .DEPTH_WORDS(P_CUR_WORDS)
    ) u_cur_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (cur_we),
        .waddr_i(wc_q[P_CUR_WAW-1:0]),
        .wdata_i(in_data),
        .raddr_i(cur_raddr),
        .rdata_o(cur_rdata)
    );

    fsbm_pix_ram #(
        .PIX_W      (PIX_W),
        .DEPTH_WORDS(P_SW_WORDS)
    ) u_sw_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (sw_we),
        .waddr_i(wc_q),
        .wdata_i(in_data),
        .raddr_i(sw_raddr),
        .rdata_o(sw_rdata)
    );

endmodule
